counter_monitor: RTL and testbench

- Hardware checker on the consumer side of the counter interface (clk, rst, en, counter_out).
- Samples the observed counter's control inputs and its count each cycle, predicts the next count, and flags reset, hold and increment violations.
- Records the first error (sticky) and keeps saturating error and check tallies for on-chip self-test of counter blocks.

---
 rtl/counter_mon_pkg.sv | 18 +
 rtl/counter_monitor_predict.sv | 30 +++
 rtl/counter_monitor.sv | 121 ++++++++++++
 tb/tb_counter_monitor.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/counter_mon_pkg.sv
// Shared types and constants for the counter monitor: FSM states, error codes
// and the default observed-count width.
package counter_mon_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CHECK,
    S_HALT
  } state_e;

  localparam logic [1:0] ERR_NONE = 2'd0;
  localparam logic [1:0] ERR_RST  = 2'd1;
  localparam logic [1:0] ERR_HOLD = 2'd2;
  localparam logic [1:0] ERR_CNT  = 2'd3;

  localparam int unsigned DEFAULT_WIDTH = 10;

endpackage

// File: rtl/counter_monitor_predict.sv
// Combinational next-count predictor: given the previous edge's reset, enable
// and count, produce the value the observed counter must show now.
module counter_predict
  import counter_mon_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             h_rst_i,
  input  logic             h_en_i,
  input  logic [WIDTH-1:0] h_count_i,
  output logic [WIDTH-1:0] exp_o,
  output logic [1:0]       code_o
);

  // Reset outranks enable, so rst and en together still predict zero.
  always_comb begin
    exp_o  = '0;
    code_o = ERR_RST;
    if (!h_rst_i) begin
      if (!h_en_i) begin
        exp_o  = h_count_i;
        code_o = ERR_HOLD;
      end else begin
        exp_o  = h_count_i + WIDTH'(1);
        code_o = ERR_CNT;
      end
    end
  end

endmodule

// File: rtl/counter_monitor.sv
// Consumer-side checker for a free-running counter: predicts each count from
// the previous edge, records the first violation and keeps saturating tallies.
module counter_monitor
  import counter_mon_pkg::*;
#(
  parameter int unsigned WIDTH       = DEFAULT_WIDTH,
  parameter int unsigned ERR_CNT_W   = 8,
  parameter bit          HALT_ON_ERR = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 mon_rst,
  input  logic                 mon_en,
  input  logic [WIDTH-1:0]     mon_count,
  input  logic                 clr_err,
  output logic                 err_valid,
  output logic [1:0]           err_code,
  output logic [WIDTH-1:0]     err_value,
  output logic [WIDTH-1:0]     err_expect,
  output logic [ERR_CNT_W-1:0] err_cnt,
  output logic [15:0]          check_cnt,
  output logic                 busy
);

  state_e               state_q, state_d;
  logic                 h_rst_q, h_en_q;
  logic [WIDTH-1:0]     h_count_q;
  logic                 err_valid_q, err_valid_d;
  logic [1:0]           err_code_q, err_code_d;
  logic [WIDTH-1:0]     err_value_q, err_value_d;
  logic [WIDTH-1:0]     err_expect_q, err_expect_d;
  logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic [15:0]          check_cnt_q, check_cnt_d;
  logic                 busy_q, busy_d;

  logic [WIDTH-1:0]     exp_w;
  logic [1:0]           code_w;
  logic                 mismatch_w;

  counter_predict #(
    .WIDTH(WIDTH)
  ) u_predict (
    .h_rst_i  (h_rst_q),
    .h_en_i   (h_en_q),
    .h_count_i(h_count_q),
    .exp_o    (exp_w),
    .code_o   (code_w)
  );

  assign mismatch_w = (mon_count != exp_w);

  // The clear is applied to the base values first, so a mismatch on the same
  // edge is recorded on top of an already-cleared error state.
  always_comb begin
    state_d      = state_q;
    err_valid_d  = clr_err ? 1'b0 : err_valid_q;
    err_code_d   = clr_err ? ERR_NONE : err_code_q;
    err_value_d  = clr_err ? '0 : err_value_q;
    err_expect_d = clr_err ? '0 : err_expect_q;
    err_cnt_d    = clr_err ? '0 : err_cnt_q;
    check_cnt_d  = clr_err ? '0 : check_cnt_q;

    unique case (state_q)
      S_IDLE: state_d = S_CHECK;
      S_CHECK: begin
        if (check_cnt_d != '1) check_cnt_d = check_cnt_d + 16'd1;
        if (mismatch_w) begin
          if (err_cnt_d != '1) err_cnt_d = err_cnt_d + ERR_CNT_W'(1);
          if (!err_valid_d) begin
            err_valid_d  = 1'b1;
            err_code_d   = code_w;
            err_value_d  = mon_count;
            err_expect_d = exp_w;
          end
          if (HALT_ON_ERR) state_d = S_HALT;
        end
      end
      S_HALT: if (clr_err) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d == S_CHECK);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      h_rst_q      <= 1'b0;
      h_en_q       <= 1'b0;
      h_count_q    <= '0;
      err_valid_q  <= 1'b0;
      err_code_q   <= ERR_NONE;
      err_value_q  <= '0;
      err_expect_q <= '0;
      err_cnt_q    <= '0;
      check_cnt_q  <= '0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      h_rst_q      <= mon_rst;
      h_en_q       <= mon_en;
      h_count_q    <= mon_count;
      err_valid_q  <= err_valid_d;
      err_code_q   <= err_code_d;
      err_value_q  <= err_value_d;
      err_expect_q <= err_expect_d;
      err_cnt_q    <= err_cnt_d;
      check_cnt_q  <= check_cnt_d;
      busy_q       <= busy_d;
    end
  end

  assign err_valid  = err_valid_q;
  assign err_code   = err_code_q;
  assign err_value  = err_value_q;
  assign err_expect = err_expect_q;
  assign err_cnt    = err_cnt_q;
  assign check_cnt  = check_cnt_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_counter_monitor.sv
// Bench for counter_monitor: two instances (free-running and halt-on-error)
// watch the same stimulus and are compared against a behavioural model.
module tb_counter_monitor;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       mon_rst = 1'b0;
  logic       mon_en = 1'b0;
  logic [9:0] mon_count = '0;
  logic       clr_err = 1'b0;

  logic       ev0, ev1, busy0, busy1;
  logic [1:0] code0, code1;
  logic [9:0] val0, val1, exp0, exp1;
  logic [7:0] ecnt0, ecnt1;
  logic [15:0] ccnt0, ccnt1;

  int tests = 0;
  int fails = 0;

  // observed-counter golden value and model state ([0] free-run, [1] halting)
  logic [9:0] gold = '0;
  int hv_rst = 0, hv_en = 0, hv_cnt = 0;
  int m_mode [2];
  int m_ev [2], m_code [2], m_val [2], m_exp [2], m_ecnt [2], m_ccnt [2];

  always #5 clk = ~clk;

  counter_monitor #(.WIDTH(10), .ERR_CNT_W(8), .HALT_ON_ERR(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .mon_rst(mon_rst), .mon_en(mon_en),
    .mon_count(mon_count), .clr_err(clr_err), .err_valid(ev0),
    .err_code(code0), .err_value(val0), .err_expect(exp0),
    .err_cnt(ecnt0), .check_cnt(ccnt0), .busy(busy0));

  counter_monitor #(.WIDTH(10), .ERR_CNT_W(8), .HALT_ON_ERR(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n), .mon_rst(mon_rst), .mon_en(mon_en),
    .mon_count(mon_count), .clr_err(clr_err), .err_valid(ev1),
    .err_code(code1), .err_value(val1), .err_expect(exp1),
    .err_cnt(ecnt1), .check_cnt(ccnt1), .busy(busy1));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic model_clear(input int i);
    m_ev[i] = 0; m_code[i] = 0; m_val[i] = 0; m_exp[i] = 0;
    m_ecnt[i] = 0; m_ccnt[i] = 0;
  endtask

  // mode: 0 waiting for first sample, 1 comparing, 2 halted
  task automatic model_edge(input int rn, input int r, input int e, input int c, input int cnt);
    int pred, why;
    pred = hv_rst ? 0 : (hv_en ? (hv_cnt + 1) % 1024 : hv_cnt);
    why  = hv_rst ? 1 : (hv_en ? 3 : 2);
    for (int i = 0; i < 2; i++) begin
      if (rn == 0) begin
        model_clear(i);
        m_mode[i] = 0;
      end else begin
        if (c != 0) model_clear(i);
        if (m_mode[i] == 0) m_mode[i] = 1;
        else if (m_mode[i] == 2) begin
          if (c != 0) m_mode[i] = 0;
        end else begin
          m_ccnt[i] = (m_ccnt[i] < 65535) ? m_ccnt[i] + 1 : 65535;
          if (cnt != pred) begin
            m_ecnt[i] = (m_ecnt[i] < 255) ? m_ecnt[i] + 1 : 255;
            if (m_ev[i] == 0) begin
              m_ev[i] = 1; m_code[i] = why; m_val[i] = cnt; m_exp[i] = pred;
            end
            if (i == 1) m_mode[i] = 2;
          end
        end
      end
    end
    if (rn == 0) begin hv_rst = 0; hv_en = 0; hv_cnt = 0; end
    else begin hv_rst = r; hv_en = e; hv_cnt = cnt; end
  endtask

  task automatic check_model();
    chk("m0_valid", ev0, m_ev[0]);     chk("m1_valid", ev1, m_ev[1]);
    chk("m0_code", code0, m_code[0]);  chk("m1_code", code1, m_code[1]);
    chk("m0_value", val0, m_val[0]);   chk("m1_value", val1, m_val[1]);
    chk("m0_expect", exp0, m_exp[0]);  chk("m1_expect", exp1, m_exp[1]);
    chk("m0_errcnt", ecnt0, m_ecnt[0]); chk("m1_errcnt", ecnt1, m_ecnt[1]);
    chk("m0_chkcnt", ccnt0, m_ccnt[0]); chk("m1_chkcnt", ccnt1, m_ccnt[1]);
    chk("m0_busy", busy0, (m_mode[0] == 1) ? 1 : 0);
    chk("m1_busy", busy1, (m_mode[1] == 1) ? 1 : 0);
  endtask

  // One clock: drive inputs, take the edge, advance model and golden counter.
  task automatic step(input logic rn, input logic r, input logic e, input logic c,
                      input logic inj, input logic [9:0] v);
    rst_n = rn; mon_rst = r; mon_en = e; clr_err = c;
    mon_count = inj ? v : gold;
    @(posedge clk);
    model_edge(int'(rn), int'(r), int'(e), int'(c), int'(mon_count));
    if (r) gold = '0;
    else if (e) gold = gold + 10'd1;
    #1;
    check_model();
  endtask

  initial begin
    logic [9:0] v;
    for (int i = 0; i < 2; i++) begin model_clear(i); m_mode[i] = 0; end
    #1;

    // monitor reset
    step(0, 0, 0, 0, 0, '0);
    step(0, 0, 0, 0, 0, '0);
    chk("rst_busy0", busy0, 0);
    chk("rst_valid0", ev0, 0);

    // golden counter: one mon_rst pulse (priming edge) then 300 checked cycles
    step(1, 1, 1, 0, 0, '0);
    repeat (300) step(1, 0, 1, 0, 0, '0);
    chk("golden_valid", ev0, 0);
    chk("golden_chkcnt", ccnt0, 300);
    chk("golden_busy", busy0, 1);
    chk("golden_busy_halt", busy1, 1);

    // legal wrap 1022 -> 1023 -> 0
    while (gold != 10'd1022) step(1, 0, 1, 0, 0, '0);
    repeat (3) step(1, 0, 1, 0, 0, '0);
    chk("wrap_valid0", ev0, 0);
    chk("wrap_valid1", ev1, 0);

    // non-zero count right after a counter reset
    step(1, 1, 1, 0, 0, '0);
    step(1, 0, 1, 0, 1, 10'd5);
    chk("rsterr_valid", ev0, 1);
    chk("rsterr_code", code0, 1);
    chk("rsterr_value", val0, 5);
    chk("rsterr_expect", exp0, 0);
    chk("rsterr_cnt", ecnt0, 1);
    chk("halt_busy", busy1, 0);
    step(1, 0, 1, 0, 1, 10'd700);
    chk("second_err_cnt0", ecnt0, 2);
    chk("first_code_kept", code0, 1);
    chk("halt_frozen_cnt", ecnt1, 1);

    // realign, then clear
    step(1, 1, 1, 0, 0, '0);
    step(1, 0, 1, 0, 0, '0);
    step(1, 0, 1, 1, 0, '0);
    chk("clr_valid0", ev0, 0);
    chk("clr_cnt0", ecnt0, 0);
    chk("clr_valid1", ev1, 0);
    chk("clr_cnt1", ecnt1, 0);
    chk("clr_prime_busy1", busy1, 0);
    step(1, 0, 1, 0, 0, '0);
    chk("reprimed_busy1", busy1, 1);
    chk("reprimed_chk1", ccnt1, 0);

    // hold violation at 37, then a skip 38 -> 40
    while (gold != 10'd37) step(1, 0, 1, 0, 0, '0);
    step(1, 0, 0, 0, 0, '0);
    step(1, 0, 0, 0, 1, 10'd38);
    chk("hold_code", code0, 2);
    chk("hold_expect", exp0, 37);
    chk("hold_value", val0, 38);
    step(1, 0, 1, 0, 1, 10'd38);
    step(1, 0, 1, 0, 1, 10'd40);
    chk("skip_cnt", ecnt0, 2);
    chk("skip_code_kept", code0, 2);

    // 300 consecutive errors saturate the tally
    v = 10'd40;
    repeat (300) begin
      v = v + 10'd2;
      step(1, 0, 1, 0, 1, v);
    end
    chk("sat_errcnt", ecnt0, 255);

    // monitor reset mid-run
    step(0, 0, 1, 0, 0, '0);
    chk("midrst_valid", ev0, 0);
    chk("midrst_errcnt", ecnt0, 0);
    chk("midrst_chkcnt", ccnt0, 0);
    chk("midrst_busy", busy0, 0);
    step(1, 0, 1, 0, 0, '0);
    chk("midrst_prime", busy0, 1);

    // randomized traffic against the model
    repeat (600) begin
      step(($urandom_range(0, 99) != 0), ($urandom_range(0, 19) == 0),
           ($urandom_range(0, 3) != 0), ($urandom_range(0, 29) == 0),
           ($urandom_range(0, 14) == 0), 10'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
